// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
// The state encoding maps directly onto the one-hot grant vector.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT0,
    ARB_GRANT1
  } arb_state_t;

  localparam int ARB_NMASTERS = 2;

  function automatic logic [ARB_NMASTERS-1:0] arb_onehot(input arb_state_t s);
    logic [ARB_NMASTERS-1:0] oh;
    oh = '0;
    if (s == ARB_GRANT0) oh = 2'b01;
    if (s == ARB_GRANT1) oh = 2'b10;
    return oh;
  endfunction

endpackage

// File: rtl/mips_arb_pick.sv
// Combinational winner selection for the two-master arbiter.
// Only meaningful when at least one request is set.
module mips_arb_pick
  import mips_bus_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [ARB_NMASTERS-1:0] req,
  input  logic                    last_grant,
  output logic                    winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      // On a tie, round-robin hands the bus to whoever did not complete last.
      2'b11:   winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: one transfer per grant, then re-arbitrate,
// with an optional watchdog that aborts a grant stuck on s_waitrequest.
module mips_avalon_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  arb_state_t       state_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;

  logic [ARB_NMASTERS-1:0] req;
  logic                    winner;
  logic                    in_grant;
  logic                    owner_is_1;
  logic                    owner_req;
  logic                    wdog_abort;

  assign req        = {m1_read | m1_write, m0_read | m0_write};
  assign in_grant   = (state_q == ARB_GRANT0) || (state_q == ARB_GRANT1);
  assign owner_is_1 = (state_q == ARB_GRANT1);
  assign owner_req  = owner_is_1 ? req[1] : req[0];
  // The watchdog fires in the last allowed stall cycle, so the master is released at that edge.
  assign wdog_abort = WDOG_EN && in_grant && owner_req && s_waitrequest && (cnt_q == CNT_LAST);

  mips_arb_pick #(
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          cnt_q <= '0;
          if (|req) state_q <= winner ? ARB_GRANT1 : ARB_GRANT0;
        end
        ARB_GRANT0, ARB_GRANT1: begin
          if (!owner_req) begin
            state_q <= ARB_IDLE;
          end else if (!s_waitrequest) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= owner_is_1;
          end else if (wdog_abort) begin
            state_q       <= ARB_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    s_address      = owner_is_1 ? m1_address    : m0_address;
    s_byteenable   = owner_is_1 ? m1_byteenable : m0_byteenable;
    s_writedata    = owner_is_1 ? m1_writedata  : m0_writedata;
    s_read         = in_grant & (owner_is_1 ? m1_read  : m0_read);
    s_write        = in_grant & (owner_is_1 ? m1_write : m0_write);
    m0_waitrequest = (state_q == ARB_GRANT0) ? (s_waitrequest & ~wdog_abort) : 1'b1;
    m1_waitrequest = (state_q == ARB_GRANT1) ? (s_waitrequest & ~wdog_abort) : 1'b1;
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign grant       = arb_onehot(state_q);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Bench for mips_avalon_arbiter: directed scenarios plus random traffic, every cycle checked
// against an owner/last-winner model of the arbitration rules and a small RAM slave.
module tb_mips_avalon_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata, s_readdata;
  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout_err;
  // fixed-priority instance shares the master and slave inputs
  logic [31:0] f_m0_readdata, f_m1_readdata, f_s_address, f_s_writedata;
  logic        f_m0_waitrequest, f_m1_waitrequest, f_s_read, f_s_write, f_timeout_err;
  logic [3:0]  f_s_byteenable;
  logic [1:0]  f_grant;

  logic [31:0] mem [0:255];
  assign s_readdata = mem[s_address[9:2]];

  int total = 0;
  int bad = 0;
  int own, lastg, cnt;
  bit terr_m;
  logic [1:0]  obs_grant, obs_fgrant;
  logic        obs_w0, obs_w1, obs_swrite;
  logic [31:0] obs_rd0, obs_rd1, obs_saddr;
  logic [31:0] exp_q[$];
  int          gseq[$];

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout_err(timeout_err)
  );

  mips_avalon_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIORITY(1), .TIMEOUT(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(f_m0_readdata), .m0_waitrequest(f_m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(f_m1_readdata), .m1_waitrequest(f_m1_waitrequest),
    .s_address(f_s_address), .s_read(f_s_read), .s_write(f_s_write),
    .s_byteenable(f_s_byteenable), .s_writedata(f_s_writedata),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(f_grant), .timeout_err(f_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare against the model mid-cycle, let the RAM react, then advance the model.
  task automatic cyc();
    bit rq0, rq1, rqn, ab;
    logic [31:0] ea;
    #1;
    rq0 = m0_read | m0_write;
    rq1 = m1_read | m1_write;
    rqn = (own == 2) ? rq1 : rq0;
    ab  = (own != 0) && rqn && s_waitrequest && (cnt + 1 == TO);
    ea  = (own == 2) ? m1_address : m0_address;
    chk("grant", grant, (own == 1) ? 32'd1 : (own == 2) ? 32'd2 : 32'd0);
    chk("s_read", s_read, (own == 0) ? 1'b0 : (own == 1) ? m0_read : m1_read);
    chk("s_write", s_write, (own == 0) ? 1'b0 : (own == 1) ? m0_write : m1_write);
    chk("s_address", s_address, ea);
    chk("s_writedata", s_writedata, (own == 2) ? m1_writedata : m0_writedata);
    chk("s_byteenable", s_byteenable, (own == 2) ? m1_byteenable : m0_byteenable);
    chk("m0_waitrequest", m0_waitrequest, (own == 1) ? (s_waitrequest && !ab) : 1'b1);
    chk("m1_waitrequest", m1_waitrequest, (own == 2) ? (s_waitrequest && !ab) : 1'b1);
    chk("timeout_err", timeout_err, terr_m);
    chk("m1_readdata", m1_readdata, mem[ea[9:2]]);
    obs_grant = grant; obs_fgrant = f_grant; obs_w0 = m0_waitrequest; obs_w1 = m1_waitrequest;
    obs_rd0 = m0_readdata; obs_rd1 = m1_readdata; obs_saddr = s_address; obs_swrite = s_write;
    @(posedge clk);
    if (reset && s_write && !s_waitrequest)
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[9:2]][8*b +: 8] = s_writedata[8*b +: 8];
    if (!reset) begin
      own = 0; lastg = 1; cnt = 0; terr_m = 0;
    end else if (own == 0) begin
      cnt = 0;
      if (rq0 && rq1) own = (lastg == 0) ? 2 : 1;
      else if (rq0)   own = 1;
      else if (rq1)   own = 2;
    end else if (!rqn) begin
      own = 0;
    end else if (!s_waitrequest) begin
      lastg = own - 1; own = 0;
    end else if (ab) begin
      own = 0; terr_m = 1;
    end else begin
      cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle_masters();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    int n, nw, idx, r0, r1;
    bit done;
    logic [31:0] a0 [4];
    logic [31:0] a1 [4];
    logic [31:0] e;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 0; s_waitrequest = 0;
    m0_read = 1; m0_write = 0; m1_read = 0; m1_write = 1;
    m0_address = 32'h40; m1_address = 32'h80;
    m0_writedata = $urandom; m1_writedata = $urandom;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    @(negedge clk);
    own = 0; lastg = 1; cnt = 0; terr_m = 0;

    // reset held with both masters requesting
    cyc(); cyc();
    chk("rst_fp_grant", f_grant, 0);
    idle_masters(); reset = 1;
    cyc();

    // solo write, zero-wait slave
    m0_write = 1; m0_address = 32'h100; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    nw = 0; idx = 0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (obs_swrite) nw++;
      if (!obs_w0) begin idx = c; break; end
    end
    m0_write = 0;
    cyc();
    if (obs_swrite) nw++;
    chk("solo_done_cycle", idx, 2);
    chk("solo_swrite_cycles", nw, 1);
    chk("solo_ram", mem[64], 32'hDEADBEEF);

    // round-robin contention, 4 reads each, starting from a fresh reset
    reset = 0; cyc(); reset = 1;
    exp_q.delete(); gseq.delete();
    for (int i = 0; i < 4; i++) begin
      a0[i] = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      a1[i] = {22'd0, 8'($urandom_range(128, 191)), 2'b00};
      exp_q.push_back(mem[a0[i][9:2]]);
      exp_q.push_back(mem[a1[i][9:2]]);
    end
    r0 = 0; r1 = 0;
    for (int c = 0; c < 40 && (r0 < 4 || r1 < 4); c++) begin
      m0_read = (r0 < 4); m0_address = a0[r0 % 4];
      m1_read = (r1 < 4); m1_address = a1[r1 % 4];
      cyc();
      if (obs_grant != 2'b00) gseq.push_back((obs_grant == 2'b10) ? 1 : 0);
      if ((m0_read && !obs_w0) || (m1_read && !obs_w1)) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk("rr_readdata", (m0_read && !obs_w0) ? obs_rd0 : obs_rd1, e);
        if (m0_read && !obs_w0) r0++; else r1++;
      end
    end
    idle_masters();
    cyc();
    chk("rr_grants", gseq.size(), 8);
    for (int i = 0; i < gseq.size() && i < 8; i++) chk("rr_order", gseq[i], i % 2);

    // fixed priority: m1 starves while m0 keeps requesting
    reset = 0; cyc(); reset = 1;
    m0_read = 1; m1_read = 1; n = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk("fp_m1_starved", obs_fgrant[1], 0);
      if (obs_fgrant == 2'b01) n++;
    end
    chk("fp_m0_served", n >= 5, 1);
    m0_read = 0; done = 0;
    for (int c = 0; c < 4 && !done; c++) begin
      cyc();
      if (obs_fgrant == 2'b10) done = 1;
    end
    chk("fp_m1_after_idle", done, 1);
    idle_masters();
    cyc(); cyc();

    // slave stall in GRANT1
    m1_write = 1; m1_address = 32'h20; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
    s_waitrequest = 1;
    cyc();
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("stall_grant", obs_grant, 2'b10);
      chk("stall_m0_wr", obs_w0, 1);
      chk("stall_m1_wr", obs_w1, 1);
      chk("stall_addr", obs_saddr, 32'h20);
    end
    s_waitrequest = 0;
    cyc();
    chk("stall_release", obs_w1, 0);
    idle_masters();
    cyc();

    // watchdog: slave never answers
    m0_read = 1; m0_address = 32'h44; s_waitrequest = 1;
    cyc();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (obs_grant == 2'b01) n++;
      if (!obs_w0) break;
    end
    m0_read = 0;
    chk("wd_stall_cycles", n, TO);
    chk("wd_err_set", timeout_err, 1);
    chk("wd_idle", grant, 2'b00);
    s_waitrequest = 0; m1_read = 1; m1_address = 32'h48; done = 0;
    for (int c = 0; c < 6 && !done; c++) begin
      cyc();
      if (!obs_w1) done = 1;
    end
    chk("wd_later_xfer", done, 1);
    m1_read = 0;
    cyc();
    chk("wd_err_sticky", timeout_err, 1);

    // random traffic, stalls, protocol errors and occasional mid-transfer reset
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 3);
        m0_read = idx[0]; m0_write = idx[1];
        m0_address = {22'd0, 8'($urandom), 2'b00};
        m0_writedata = $urandom; m0_byteenable = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, 3);
        m1_read = idx[0]; m1_write = idx[1];
        m1_address = {22'd0, 8'($urandom), 2'b00};
        m1_writedata = $urandom; m1_byteenable = 4'($urandom);
      end
      s_waitrequest = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
